// File: rtl/stage4_memory.sv
// stage4_memory: pipeline stage 4, data-memory access over a req/ack bus with timeout.
// Ports: clk_i/rst_i; stall_i (from stage 5), stall_o (to stage 3); alu_i, control_load_i,
//   control_store_i, store_data_i, do_wb_i, wb_reg_i (op from stage 3); mem_req_o, mem_we_o,
//   mem_addr_o, mem_data_o, mem_ack_i, mem_data_i, mem_err_o (data bus); wb_data_o, do_wb_o,
//   wb_reg_o (writeback to stage 5).
module stage4_memory #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        stall_o,
  input  logic        stall_i,
  input  logic [31:0] alu_i,
  input  logic        control_load_i,
  input  logic        control_store_i,
  input  logic [31:0] store_data_i,
  input  logic        do_wb_i,
  input  logic [4:0]  wb_reg_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [29:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  output logic        mem_err_o,
  output logic [31:0] wb_data_o,
  output logic        do_wb_o,
  output logic [4:0]  wb_reg_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] alu;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        load;
  logic        store;
  logic        do_wb;
  logic [4:0]  wb_reg;
  logic [7:0]  wait_cnt;
  logic        err;
  logic        in_req;
  logic        advance;
  logic        ack;
  logic        timeout;

  assign in_req  = (state == S_REQ);
  assign stall_o = stall_i | in_req;
  assign advance = !stall_o;
  // ack is only meaningful while a transaction is on the bus
  assign ack     = in_req & mem_ack_i;
  assign timeout = in_req & !mem_ack_i & (wait_cnt == TO_LAST);

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (advance) begin
          state_nxt = (control_load_i | control_store_i) ? S_REQ : S_IDLE;
        end
      end
      S_REQ: begin
        if (ack | timeout) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // bus outputs, driven only while a transaction is active
  always_comb begin
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    if (in_req) begin
      mem_req_o  = 1'b1;
      mem_we_o   = store & !load;
      mem_addr_o = alu[31:2];
      mem_data_o = store_data;
    end
  end

  // op registers from stage 3
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alu        <= '0;
      load       <= 1'b0;
      store      <= 1'b0;
      store_data <= '0;
      do_wb      <= 1'b0;
      wb_reg     <= '0;
    end else if (advance) begin
      alu        <= alu_i;
      load       <= control_load_i;
      store      <= control_store_i;
      store_data <= store_data_i;
      do_wb      <= do_wb_i;
      wb_reg     <= wb_reg_i;
    end
  end

  // wait counter is held at zero outside S_REQ so every entry starts from 0
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt  <= '0;
      load_data <= '0;
      err       <= 1'b0;
    end else begin
      err <= timeout;
      if (!in_req) begin
        wait_cnt <= '0;
      end else if (!mem_ack_i) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (ack & load) begin
        load_data <= mem_data_i;
      end else if (timeout) begin
        load_data <= '1;
      end
    end
  end

  assign mem_err_o = err;
  assign wb_data_o = load ? load_data : alu;
  assign wb_reg_o  = wb_reg;
  // suppress writeback while the bus result is not yet known
  assign do_wb_o   = do_wb & !in_req;

endmodule

// File: tb/tb_stage4_memory.sv
// tb_stage4_memory: randomized scoreboard bench for stage4_memory.
// Driver issues ops into a model-fed queue; monitor and bus responder run independently.
module tb_stage4_memory;

  localparam int T = 4;
  localparam int N_RAND = 300;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_o;
  logic        stall_i;
  logic [31:0] alu_i;
  logic        control_load_i;
  logic        control_store_i;
  logic [31:0] store_data_i;
  logic        do_wb_i;
  logic [4:0]  wb_reg_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [29:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic        mem_err_o;
  logic [31:0] wb_data_o;
  logic        do_wb_o;
  logic [4:0]  wb_reg_o;

  always #5 clk_i = ~clk_i;

  stage4_memory #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .stall_o         (stall_o),
    .stall_i         (stall_i),
    .alu_i           (alu_i),
    .control_load_i  (control_load_i),
    .control_store_i (control_store_i),
    .store_data_i    (store_data_i),
    .do_wb_i         (do_wb_i),
    .wb_reg_i        (wb_reg_i),
    .mem_req_o       (mem_req_o),
    .mem_we_o        (mem_we_o),
    .mem_addr_o      (mem_addr_o),
    .mem_data_o      (mem_data_o),
    .mem_ack_i       (mem_ack_i),
    .mem_data_i      (mem_data_i),
    .mem_err_o       (mem_err_o),
    .wb_data_o       (wb_data_o),
    .do_wb_o         (do_wb_o),
    .wb_reg_o        (wb_reg_o)
  );

  typedef struct {
    logic [31:0] alu;
    logic        ld;
    logic        st;
    logic [31:0] sd;
    logic        dwb;
    logic [4:0]  rd;
    int          dly;
  } op_t;

  typedef struct {
    bit          tag;
    logic [29:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] wb_data;
    logic        do_wb;
    logic [4:0]  wb_reg;
    logic        err;
    int          req_cycles;
  } exp_t;

  exp_t        exp_q[$];
  int          dly_q[$];
  op_t         ops[$];
  logic [31:0] ref_mem[16];
  logic [31:0] bus_mem[16];
  int          checks = 0;
  int          passed = 0;
  int          real_pops = 0;
  bit          mon_en = 1'b0;
  bit          resp_en = 1'b0;
  logic        resp_ack = 1'b0;
  logic [31:0] resp_data = '0;
  logic        man_ack = 1'b0;
  logic [31:0] man_data = '0;

  assign mem_ack_i  = resp_en ? resp_ack : man_ack;
  assign mem_data_i = resp_en ? resp_data : man_data;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Reference: outcome of one op decided from its kind and the bus delay.
  function automatic exp_t model(input op_t o, input bit tag);
    exp_t       e;
    bit         mem_op;
    bit         to;
    logic [3:0] idx;
    mem_op       = o.ld | o.st;
    to           = mem_op && (o.dly >= T);
    idx          = o.alu[5:2];
    e.tag        = tag;
    e.addr       = o.alu[31:2];
    e.we         = o.st & !o.ld;
    e.wdata      = o.sd;
    e.do_wb      = o.dwb;
    e.wb_reg     = o.rd;
    e.err        = to;
    e.req_cycles = !mem_op ? 0 : (to ? T : o.dly + 1);
    if (o.ld) e.wb_data = to ? 32'hFFFF_FFFF : ref_mem[idx];
    else e.wb_data = o.alu;
    if (mem_op && !o.ld && !to) ref_mem[idx] = o.sd;
    return e;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int  k;
    k     = $urandom_range(0, 3);
    o.alu = $urandom();
    o.ld  = (k == 1) || (k == 3);
    o.st  = (k >= 2);
    o.sd  = $urandom();
    o.dwb = 1'($urandom_range(0, 1));
    o.rd  = 5'($urandom_range(0, 31));
    o.dly = $urandom_range(0, 5);
    return o;
  endfunction

  function automatic op_t mk(input logic [31:0] a, input logic l,
                             input logic s, input logic [31:0] d,
                             input logic w, input logic [4:0] r,
                             input int dl);
    op_t o;
    o.alu = a; o.ld = l; o.st = s; o.sd = d;
    o.dwb = w; o.rd = r; o.dly = dl;
    return o;
  endfunction

  task automatic drive(input op_t o);
    alu_i           = o.alu;
    control_load_i  = o.ld;
    control_store_i = o.st;
    store_data_i    = o.sd;
    do_wb_i         = o.dwb;
    wb_reg_i        = o.rd;
  endtask

  // bus responder: acks after the delay chosen when the op was issued,
  // and toggles junk acks while no request is active
  int cur_dly = 0;
  int kcnt = 0;
  bit req_prev = 1'b0;
  always @(negedge clk_i) begin
    if (resp_en) begin
      if (mem_req_o) begin
        if (!req_prev) begin
          kcnt = 0;
          if (dly_q.size() > 0) cur_dly = dly_q.pop_front();
          else cur_dly = 1000;
        end else begin
          kcnt++;
        end
        resp_ack  = (kcnt == cur_dly);
        resp_data = $urandom();
        if (resp_ack) begin
          if (mem_we_o) bus_mem[mem_addr_o[3:0]] = mem_data_o;
          else resp_data = bus_mem[mem_addr_o[3:0]];
        end
      end else begin
        resp_ack  = 1'($urandom_range(0, 1));
        resp_data = $urandom();
      end
      req_prev = mem_req_o;
    end
  end

  // monitor: an op captured at an edge is presented on the first
  // following cycle with no bus request
  bit pending = 1'b0;
  int req_cnt = 0;
  always @(negedge clk_i) begin : mon
    exp_t e;
    if (mon_en) begin
      #1;
      if (pending) begin
        if (exp_q.size() == 0) begin
          chk("queue_nonempty", 32'(exp_q.size()), 32'd1);
          pending = 1'b0;
        end else if (mem_req_o) begin
          req_cnt++;
          chk("mem_addr", 32'(mem_addr_o), 32'(exp_q[0].addr));
          chk("mem_we", 32'(mem_we_o), 32'(exp_q[0].we));
          chk("mem_data", mem_data_o, exp_q[0].wdata);
          chk("do_wb_in_req", 32'(do_wb_o), 32'd0);
          chk("err_in_req", 32'(mem_err_o), 32'd0);
          chk("stall_in_req", 32'(stall_o), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("wb_data", wb_data_o, e.wb_data);
          chk("do_wb", 32'(do_wb_o), 32'(e.do_wb));
          chk("wb_reg", 32'(wb_reg_o), 32'(e.wb_reg));
          chk("mem_err", 32'(mem_err_o), 32'(e.err));
          chk("req_cycles", 32'(req_cnt), 32'(e.req_cycles));
          chk("idle_addr", 32'(mem_addr_o), 32'd0);
          chk("idle_we", 32'(mem_we_o), 32'd0);
          chk("idle_data", mem_data_o, 32'd0);
          if (e.tag) real_pops++;
          pending = 1'b0;
          req_cnt = 0;
        end
      end
      if (!stall_o) pending = 1'b1;
    end
  end

  initial begin
    op_t         cur;
    op_t         nop;
    bit          have;
    int          idx;
    int          budget;
    logic [31:0] v;

    nop = mk(32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 0);
    for (int i = 0; i < 16; i++) begin
      v = $urandom();
      ref_mem[i] = v;
      bus_mem[i] = v;
    end
    ref_mem[0] = 32'hCAFE_F00D;
    bus_mem[0] = 32'hCAFE_F00D;

    ops.push_back(mk(32'h0000_1234, 0, 0, 32'h0, 1, 5'd3, 0));
    ops.push_back(mk(32'h0000_0100, 1, 0, 32'h0, 1, 5'd7, 2));
    ops.push_back(mk(32'h0000_0204, 0, 1, 32'hA5A5_A5A5, 0, 5'd0, 0));
    ops.push_back(mk(32'h0000_0080, 1, 0, 32'h0, 1, 5'd9, 9));
    ops.push_back(mk(32'h0000_0204, 1, 0, 32'h0, 1, 5'd10, 1));
    ops.push_back(mk(32'h0000_0008, 0, 1, 32'h1122_3344, 0, 5'd0, 0));
    ops.push_back(mk(32'h0000_0007, 1, 1, 32'h5555_0000, 1, 5'd11, 0));
    for (int i = 0; i < N_RAND; i++) ops.push_back(rand_op());

    rst_i = 1'b1;
    stall_i = 1'b0;
    drive(nop);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_mem_we", 32'(mem_we_o), 32'd0);
    chk("rst_mem_err", 32'(mem_err_o), 32'd0);
    chk("rst_do_wb", 32'(do_wb_o), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr_o), 32'd0);
    chk("rst_mem_data", mem_data_o, 32'd0);
    chk("rst_wb_data", wb_data_o, 32'd0);
    chk("rst_wb_reg", 32'(wb_reg_o), 32'd0);
    chk("rst_stall_lo", 32'(stall_o), 32'd0);
    stall_i = 1'b1;
    #1;
    chk("rst_stall_hi", 32'(stall_o), 32'd1);
    stall_i = 1'b0;
    rst_i = 1'b0;
    mon_en = 1'b1;
    resp_en = 1'b1;

    have = 1'b0;
    idx = 0;
    budget = 20000;
    while (real_pops < ops.size() && budget > 0) begin
      @(negedge clk_i);
      budget--;
      if (!have && idx < ops.size()) begin
        cur = ops[idx];
        have = 1'b1;
      end
      drive(have ? cur : nop);
      stall_i = ($urandom_range(0, 3) == 0);
      #1;
      if (!stall_o) begin
        exp_q.push_back(model(have ? cur : nop, have));
        if (have && (cur.ld || cur.st)) dly_q.push_back(cur.dly);
        if (have) begin
          idx++;
          have = 1'b0;
        end
      end
    end
    chk("all_ops_retired", 32'(real_pops), 32'(ops.size()));

    // reset while a load sits in its second bus cycle
    @(negedge clk_i);
    mon_en = 1'b0;
    resp_en = 1'b0;
    man_ack = 1'b0;
    stall_i = 1'b0;
    drive(mk(32'h0000_0300, 1, 0, 32'h0, 1, 5'd4, 0));
    #1;
    chk("mid_issue", 32'(stall_o), 32'd0);
    @(negedge clk_i);
    drive(nop);
    #1;
    chk("mid_req1", 32'(mem_req_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("mid_req2", 32'(mem_req_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    man_ack = 1'b1;
    man_data = 32'hDEAD_BEEF;
    #1;
    chk("mid_req_drop", 32'(mem_req_o), 32'd0);
    chk("mid_stall", 32'(stall_o), 32'd0);
    chk("mid_wb_data", wb_data_o, 32'd0);
    chk("mid_do_wb", 32'(do_wb_o), 32'd0);
    chk("mid_wb_reg", 32'(wb_reg_o), 32'd0);
    @(negedge clk_i);
    man_ack = 1'b0;
    #1;
    chk("late_ack_req", 32'(mem_req_o), 32'd0);
    chk("late_ack_wb", wb_data_o, 32'd0);
    chk("late_ack_err", 32'(mem_err_o), 32'd0);
    chk("late_ack_addr", 32'(mem_addr_o), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/stage4_memory.md
STAGE4_MEMORY -- requirements
Module: stage4_memory

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles waiting in S_REQ for mem_ack_i; range 1..255.
REQ-002 clk_i  in  1  sole clock; all state changes on rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 stall_o  out  1  to stage 3; holds stage 3 outputs.
REQ-005 stall_i  in  1  from stage 5; holds this stage.
REQ-006 alu_i  in  32  ALU result from stage 3; memory byte address for load/store.
REQ-007 control_load_i  in  1  op is a word load.
REQ-008 control_store_i  in  1  op is a word store.
REQ-009 store_data_i  in  32  store data.
REQ-010 do_wb_i  in  1  op writes a register.
REQ-011 wb_reg_i  in  5  destination register.
REQ-012 mem_req_o  out  1  data-bus request.
REQ-013 mem_we_o  out  1  1 = write, 0 = read; valid while mem_req_o = 1.
REQ-014 mem_addr_o  out  30  word address.
REQ-015 mem_data_o  out  32  write data.
REQ-016 mem_ack_i  in  1  bus completion, sampled only in S_REQ.
REQ-017 mem_data_i  in  32  read data, valid with mem_ack_i.
REQ-018 mem_err_o  out  1  one-cycle pulse on bus timeout.
REQ-019 wb_data_o  out  32  writeback value to stage 5.
REQ-020 do_wb_o  out  1  writeback enable to stage 5.
REQ-021 wb_reg_o  out  5  writeback register to stage 5.

Function
REQ-022 advance = !stall_o; stall_o = stall_i | (state == S_REQ).
REQ-023 On advance, the stage SHALL register alu_i, control_load_i, control_store_i, store_data_i, do_wb_i and wb_reg_i; otherwise it SHALL hold all registered values.
REQ-024 FSM states: S_IDLE (no memory op pending), S_REQ (bus transaction active), S_DONE (memory op complete, result held).
REQ-025 On advance, next state SHALL be S_REQ if control_load_i | control_store_i is 1, else S_IDLE; this applies in S_IDLE and S_DONE.
REQ-026 In S_REQ, mem_req_o = 1, mem_addr_o = registered alu[31:2], mem_we_o = store & !load, mem_data_o = registered store data; all SHALL remain stable until ack or timeout.
REQ-027 Outside S_REQ, mem_req_o = 0; mem_addr_o, mem_we_o and mem_data_o SHALL be 0.
REQ-028 In S_REQ with mem_ack_i = 1: latch mem_data_i into load_data (loads only); next state S_DONE; stall_o SHALL remain 1 in that cycle.
REQ-029 Minimum memory-op latency: one stall cycle (ack in the first S_REQ cycle); each ack-delay cycle adds one stall cycle.
REQ-030 A wait counter SHALL clear on S_REQ entry and increment each S_REQ cycle without ack; on reaching TIMEOUT_CYCLES: pulse mem_err_o for 1 cycle, set load_data = 32'hFFFFFFFF, next state S_DONE.
REQ-031 mem_ack_i outside S_REQ SHALL be ignored.
REQ-032 If load and store are both set, the op SHALL be treated as a load (mem_we_o = 0).
REQ-033 wb_data_o SHALL equal load_data when the registered op is a load, else the registered alu value.
REQ-034 wb_reg_o SHALL equal the registered wb_reg.
REQ-035 do_wb_o SHALL equal registered do_wb & (state != S_REQ), so no bubble write occurs while the bus is pending.
REQ-036 stall_i asserted during S_REQ SHALL NOT suspend the bus transaction; completion moves to S_DONE and the stage holds until stall_i drops.
REQ-037 Address bits [1:0] SHALL be ignored; no alignment fault.

Reset
REQ-038 On rst_i at a clock edge: state S_IDLE, wait counter 0, all registered values 0, load_data 0.
REQ-039 After reset: mem_req_o, mem_we_o, mem_err_o, do_wb_o = 0; mem_addr_o, mem_data_o, wb_data_o = 0; wb_reg_o = 0; stall_o = stall_i.
REQ-040 Reset during S_REQ SHALL drop mem_req_o the next cycle, abandon the transaction, and ignore a later ack.

Verification
REQ-041 ALU op: alu_i=0x1234, do_wb_i=1, wb_reg_i=3, no mem -> next cycle wb_data_o=0x1234, do_wb_o=1, wb_reg_o=3, stall_o=0.
REQ-042 Load: alu_i=0x100, ack 2 cycles after req with mem_data_i=0xCAFEF00D -> mem_addr_o=0x40, stall_o high 3 cycles, then wb_data_o=0xCAFEF00D, do_wb_o=1.
REQ-043 Store: alu_i=0x204, store_data_i=0xA5A5A5A5, ack in first cycle -> mem_we_o=1, mem_addr_o=0x81, mem_data_o=0xA5A5A5A5, exactly 1 stall cycle.
REQ-044 Timeout: TIMEOUT_CYCLES=4, load, never ack -> mem_req_o high 4 cycles, mem_err_o 1-cycle pulse, wb_data_o=0xFFFFFFFF.
REQ-045 Back-to-back: load then store with stall_i=1 asserted during the first ack -> load completes, stage holds in S_DONE, store captured only after stall_i drops.
REQ-046 Reset mid-op: rst_i in 2nd S_REQ cycle, then ack -> mem_req_o=0 next cycle, ack ignored, all outputs at reset values.
